fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Handles stalls from the hazard unit and redirects from branch/jump resolution.
- Presents the fetched instruction word `IR` with its PC to the decode stage: immediate generator, decoder, register-file read.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock, reset asynchronous and active-low.
- `imem_req`  out  1  fetch request; level, held until `imem_ack`.
- `imem_addr`  out  32  word-aligned fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  response valid this cycle; may coincide with the first cycle of `imem_req` (zero-wait).
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `redirect`  in  1  taken branch/jump/JALR from EX; flush and refetch.
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 0).
- `stall`  in  1  hazard unit: hold IF/ID contents.
- `IR`  out  32  IF/ID instruction word, registered.
- `id_pc`  out  32  PC of `IR`.
- `id_pc4`  out  32  `id_pc`+4, for JAL/JALR link.
- `id_valid`  out  1  `IR` is a real instruction (0 = bubble).

## Operation
- State machine: FETCH, DROP, HOLD. Reset state is FETCH.
- Internal registers: `pc`, `drop_addr`, buffer `{buf_ir, buf_pc}`.
- `imem_req` = 1 in FETCH and DROP, 0 in HOLD.
- `imem_addr` = `pc` in FETCH and `drop_addr` in DROP; don't-care in HOLD.

FETCH transitions:
- ack, no redirect, no stall: IF/ID <= {rdata, pc, pc+4, valid=1}; `pc` <= `pc`+4; stay in FETCH.
- ack, stall, no redirect: buffer <= {rdata, pc}; `pc` <= `pc`+4; go to HOLD; IF/ID unchanged.
- No ack, no redirect: stay in FETCH; `pc` unchanged.
- redirect with ack: discard rdata; `pc` <= target; stay in FETCH.
- redirect without ack: `drop_addr` <= `pc`; `pc` <= target; go to DROP.

DROP transitions:
- DROP re-presents the stale request until it completes.
- ack: discard rdata; go to FETCH.
- Another redirect while in DROP: `pc` <= new target; remain in DROP until the stale ack.

HOLD transitions:
- No stall: IF/ID <= {buf_ir, buf_pc, buf_pc+4, 1}; go to FETCH.
- redirect: drop the buffer; `pc` <= target; go to FETCH.

IF/ID update priority, highest first:
1. redirect: `IR` <= NOP 32'h0000_0013 and `id_valid` <= 0. `id_pc` and `id_pc4` keep their previous values.
2. stall: hold all IF/ID outputs.
3. Accepted instruction (from rdata or buffer): load it.
4. Otherwise: bubble, i.e. `IR` <= NOP and `id_valid` <= 0.

Arithmetic and reset:
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset values: `pc`=`RESET_PC`, `IR`=NOP, `id_pc`=0, `id_pc4`=0, `id_valid`=0, buffer=0, state=FETCH.
- Immediately after reset release, `imem_req`=1 and `imem_addr`=`RESET_PC`.
- Reset asserted mid-transaction abandons the transaction with no wait for ack. The memory side must tolerate this.

## Timing
- Zero-wait memory (ack in the same cycle as req): the instruction appears on `IR` at the edge closing the ack cycle. Throughput is 1 instruction/cycle.
- N-wait memory: one instruction per N+1 cycles; bubbles are inserted between instructions.
- Redirect at edge k: `IR`=NOP and `id_valid`=0 after edge k.
  - Zero-wait memory, no DROP: first target instruction on `IR` after edge k+1.
  - In DROP: first target instruction follows the stale ack by ≥1 request cycle.
- Stall is sampled each edge. While stall=1, at most one fetched instruction is buffered (HOLD) and `imem_req`=0.
- Release from HOLD: buffered instruction on `IR` one edge after stall falls. The next request issues in the following cycle.

## Structure
- Shared constants go in `defines.v`: `INSTR_NOP` (32'h0000_0013), the FETCH/DROP/HOLD state encodings, and the `RESET_PC` default.
- One natural sub-module: `if_id_register`, holding `IR`/`id_pc`/`id_pc4`/`id_valid` with flush>stall>load>bubble priority.
- The FSM, PC and buffer stay in `fetch_stage`.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr+0x100: `IR` = 0x100, 0x104, 0x108 on consecutive cycles, `id_pc` 0, 4, 8, `id_pc4` 4, 8, 12.
- 2-wait memory: `imem_addr` stays 0x0 for 3 cycles; `id_valid` pattern 0,0,1 repeating.
- Stall asserted for 3 cycles while ack arrives for PC 0x8: IF/ID holds the 0x4 instruction, `imem_req`=0 in HOLD. After stall drops, `IR` = word for 0x8 next edge, then fetch resumes at 0xC.
- Redirect to 0x200 during the wait cycle of fetch 0x10 (2-wait memory): `IR`=NOP and `id_valid`=0 next edge; `imem_addr` stays 0x10 until ack with rdata discarded; next request at 0x200.
- Redirect and stall in the same cycle: flush wins (`id_valid`=0). Redirect to 0x203: fetch address 0x200.
- PC at 0xFFFF_FFFC, zero-wait memory: next `imem_addr` = 0x0. Async `rst` low mid-wait: outputs take reset values immediately.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_DROP  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } fetch_word_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble is inserted.
module if_id_register
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        load_i,
   input  fetch_word_t word_i,
   output logic [31:0] ir_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] ir_q, ir_d, pc_q, pc_d, pc4_q, pc4_d;
   logic        valid_q, valid_d;

   // Next IF/ID contents; a flush keeps the old PC fields on purpose.
   always_comb begin
      ir_d    = ir_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush_i) begin
         ir_d    = INSTR_NOP;
         valid_d = 1'b0;
      end else if (stall_i) begin
         ir_d    = ir_q;
         valid_d = valid_q;
      end else if (load_i) begin
         ir_d    = word_i.ir;
         pc_d    = word_i.pc;
         pc4_d   = word_i.pc + 32'd4;
         valid_d = 1'b1;
      end else begin
         ir_d    = INSTR_NOP;
         valid_d = 1'b0;
      end
   end

   // IF/ID state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_q    <= INSTR_NOP;
         pc_q    <= 32'd0;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign ir_o    = ir_q;
   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack memory handshake, stall buffering and redirect flush.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] IR,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, drop_addr_q, drop_addr_d;
   fetch_word_t buf_q, buf_d;
   fetch_word_t load_word_s;
   logic        load_s;
   logic [31:0] target_s;

   assign target_s = word_align(redirect_pc);

   // FSM, PC and holding-buffer next state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      buf_d       = buf_q;
      case (state_q)
         ST_FETCH: begin
            if (redirect) begin
               pc_d = target_s;
               if (imem_ack) begin
                  state_d = ST_FETCH;
               end else begin
                  drop_addr_d = pc_q;
                  state_d     = ST_DROP;
               end
            end else if (imem_ack) begin
               pc_d = pc_q + 32'd4;
               if (stall) begin
                  buf_d   = {imem_rdata, pc_q};
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DROP: begin
            // The stale request must complete before the target is fetched.
            if (redirect) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
            if (imem_ack) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = target_s;
               state_d = ST_FETCH;
            end else if (!stall) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // FSM, PC and buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= 32'd0;
         buf_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         buf_q       <= buf_d;
      end
   end

   assign imem_req    = (state_q != ST_HOLD);
   assign imem_addr   = (state_q == ST_DROP) ? drop_addr_q : pc_q;
   assign load_s      = ((state_q == ST_FETCH) && imem_ack) || (state_q == ST_HOLD);
   assign load_word_s = (state_q == ST_HOLD) ? buf_q : {imem_rdata, pc_q};

   if_id_register u_if_id (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .stall_i (stall),
      .load_i  (load_s),
      .word_i  (load_word_s),
      .ir_o    (IR),
      .pc_o    (id_pc),
      .pc4_o   (id_pc4),
      .valid_o (id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: wait-state memory model, transaction-level reference, directed vectors.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0, redirect = 1'b0, stall = 1'b0, id_valid;
   logic [31:0] imem_addr, imem_rdata = 32'd0, redirect_pc = 32'd0, IR, id_pc, id_pc4;

   int errors = 0;
   int checks = 0;
   int wait_n = 0;
   int mem_cnt = 0;
   int n;
   bit chk_en = 1'b0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .IR          (IR),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4),
      .id_valid    (id_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: acks after wait_n request cycles and returns addr+0x100.
   always @(negedge clk) begin
      #1;
      if (imem_req === 1'b1 && mem_cnt >= wait_n) begin
         imem_ack   = 1'b1;
         imem_rdata = imem_addr + 32'h100;
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) mem_cnt <= 0;
      else if (imem_req === 1'b1 && !imem_ack) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
   end

   // Reference model in transaction terms: an outstanding stale fetch, a one-entry buffer, the IF/ID slot.
   logic [31:0] m_pc, m_stale_addr, m_ir, m_id_pc, m_id_pc4, m_buf_ir, m_buf_pc;
   bit          m_stale, m_buf_full, m_valid, m_got;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc = 32'd0; m_stale = 0; m_buf_full = 0; m_buf_ir = 32'd0; m_buf_pc = 32'd0;
         m_ir = NOP; m_id_pc = 32'd0; m_id_pc4 = 32'd0; m_valid = 0;
      end else if (redirect) begin
         m_ir = NOP; m_valid = 0;
         if (m_buf_full) m_buf_full = 0;
         else if (m_stale) begin
            if (imem_ack) m_stale = 0;
         end else if (!imem_ack) begin
            m_stale = 1; m_stale_addr = m_pc;
         end
         m_pc = {redirect_pc[31:2], 2'b00};
      end else if (m_buf_full) begin
         if (!stall) begin
            m_ir = m_buf_ir; m_id_pc = m_buf_pc; m_id_pc4 = m_buf_pc + 32'd4;
            m_valid = 1; m_buf_full = 0;
         end
      end else begin
         m_got = imem_ack && !m_stale;
         if (imem_ack && m_stale) m_stale = 0;
         if (m_got && stall) begin
            m_buf_ir = imem_rdata; m_buf_pc = m_pc; m_buf_full = 1;
         end else if (m_got) begin
            m_ir = imem_rdata; m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_valid = 1;
         end else if (!stall) begin
            m_ir = NOP; m_valid = 0;
         end
         if (m_got) m_pc = m_pc + 32'd4;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst && chk_en) begin
         chk("imem_req", imem_req, !m_buf_full);
         if (!m_buf_full) chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
         chk("IR", IR, m_ir);
         chk("id_pc", id_pc, m_id_pc);
         chk("id_pc4", id_pc4, m_id_pc4);
         chk("id_valid", id_valid, m_valid);
      end
   end

   initial begin
      #1 rst = 1'b0;
      #20;
      chk("rst_IR", IR, NOP);
      chk("rst_valid", id_valid, 1'b0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_pc4", id_pc4, 32'd0);
      chk("rst_req", imem_req, 1'b1);
      chk("rst_addr", imem_addr, 32'd0);

      // Zero-wait streaming.
      @(negedge clk); rst = 1'b1; chk_en = 1'b1;
      @(posedge clk); #1; chk("zw_IR0", IR, 32'h100); chk("zw_pc0", id_pc, 32'h0); chk("zw_pc4_0", id_pc4, 32'h4);
      @(posedge clk); #1; chk("zw_IR1", IR, 32'h104); chk("zw_pc1", id_pc, 32'h4); chk("zw_pc4_1", id_pc4, 32'h8);
      @(posedge clk); #1; chk("zw_IR2", IR, 32'h108); chk("zw_pc2", id_pc, 32'h8); chk("zw_pc4_2", id_pc4, 32'hC);

      // Two wait states: one instruction every three cycles.
      @(negedge clk); wait_n = 2;
      repeat (3) @(posedge clk);
      #1; chk("w2_IR0", IR, 32'h10C); chk("w2_valid0", id_valid, 1'b1);
      repeat (3) @(posedge clk);
      #1; chk("w2_IR1", IR, 32'h110);

      // Stall for three edges while the 0x14 fetch is acked.
      @(negedge clk); wait_n = 0; stall = 1'b1;
      @(posedge clk); #1; chk("hold_req", imem_req, 1'b0); chk("hold_IR", IR, 32'h110);
      repeat (3) @(negedge clk);
      stall = 1'b0;
      @(posedge clk); #1; chk("rel_IR", IR, 32'h114); chk("rel_pc", id_pc, 32'h14);
      @(posedge clk); #1; chk("resume_IR", IR, 32'h118);

      // Redirect during a wait cycle, two-wait memory.
      @(negedge clk); wait_n = 2;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h200;
      @(posedge clk); #1;
      chk("rd_IR", IR, NOP); chk("rd_valid", id_valid, 1'b0); chk("rd_drop_addr", imem_addr, 32'h1C);
      @(negedge clk); redirect = 1'b0;
      n = 0;
      while (id_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("rd_target_timeout", id_valid, 1'b1);
      chk("rd_target_IR", IR, 32'h300);
      chk("rd_target_pc", id_pc, 32'h200);

      // Redirect and stall together; unaligned target.
      @(negedge clk); wait_n = 0; redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
      @(posedge clk); #1; chk("rs_valid", id_valid, 1'b0); chk("rs_IR", IR, NOP); chk("rs_addr", imem_addr, 32'h200);
      @(negedge clk); redirect = 1'b0; stall = 1'b0;
      @(posedge clk); #1; chk("rs_IR2", IR, 32'h300); chk("rs_pc2", id_pc, 32'h200);

      // PC wrap-around.
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk); #1; chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk); redirect = 1'b0;
      @(posedge clk); #1;
      chk("wrap_IR", IR, 32'h0000_00FC); chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", id_pc4, 32'h0); chk("wrap_addr1", imem_addr, 32'h0);

      // Asynchronous reset in the middle of a wait.
      @(negedge clk); wait_n = 2;
      @(posedge clk);
      @(negedge clk); #3 rst = 1'b0;
      #1;
      chk("arst_IR", IR, NOP); chk("arst_valid", id_valid, 1'b0); chk("arst_id_pc", id_pc, 32'd0);
      chk("arst_id_pc4", id_pc4, 32'd0); chk("arst_req", imem_req, 1'b1); chk("arst_addr", imem_addr, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
